reg_write_arbiter: RTL and testbench

//  Round-robin arbiter sharing one bank of load-enabled registers (Register/Bit

---
 rtl/reg_write_arbiter.sv | 178 +++++++++++++++++
 tb/tb_reg_write_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter in front of a bank of load-enabled registers.
// One requester owns the bank at a time for a bounded burst; each accepted
// write becomes a registered one-hot load strobe plus data one cycle later.
module reg_write_arbiter #(
   parameter int N_REQ     = 4,
   parameter int WIDTH     = 16,
   parameter int N_REG     = 6,
   parameter int ADDR_W    = 3,
   parameter int MAX_BURST = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ-1:0]        req_last,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   input  logic [N_REQ*WIDTH-1:0]  req_data,
   output logic [N_REQ-1:0]        req_ready,
   output logic [N_REG-1:0]        reg_load,
   output logic [WIDTH-1:0]        reg_in,
   output logic [2:0]              grant_id,
   output logic                    busy,
   output logic                    err_addr
);

   localparam int ID_W  = 3;
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic {
      IDLE,
      OWNED
   } state_t;

   state_t           state;
   logic [ID_W-1:0]  owner;
   logic [ID_W-1:0]  rr_ptr;
   logic [CNT_W-1:0] burst_cnt;

   // ------------------------------------------------------------------
   // Round-robin pick: prefer requesters at or above rr_ptr, otherwise
   // wrap to the lowest index. The lowest set bit is isolated with the
   // two's-complement trick and then encoded bit-by-bit, which keeps every
   // select constant and avoids a priority chain.
   // ------------------------------------------------------------------
   logic [N_REQ-1:0]            upper_mask;
   logic [N_REQ-1:0]            upper_req;
   logic [N_REQ-1:0]            cand_req;
   logic [N_REQ-1:0]            first;
   logic [ID_W-1:0][N_REQ-1:0]  enc_mask;
   logic [ID_W-1:0]             pick;
   logic                        any_req;

   for (genvar g = 0; g < N_REQ; g++) begin : g_arb
      assign upper_mask[g] = (ID_W'(g) >= rr_ptr);
   end

   for (genvar b = 0; b < ID_W; b++) begin : g_enc
      for (genvar g = 0; g < N_REQ; g++) begin : g_enc_bit
         assign enc_mask[b][g] = (((g >> b) & 1) != 0);
      end
      assign pick[b] = |(first & enc_mask[b]);
   end

   assign upper_req = req_valid & upper_mask;
   assign cand_req  = (|upper_req) ? upper_req : req_valid;
   assign first     = cand_req & (~cand_req + 1'b1);
   assign any_req   = |req_valid;

   // ------------------------------------------------------------------
   // Owner's request fields, selected by an AND-OR mux over a one-hot
   // decode of the registered owner index.
   // ------------------------------------------------------------------
   logic [N_REQ-1:0]             own_sel;
   logic [ADDR_W-1:0][N_REQ-1:0] addr_t;
   logic [WIDTH-1:0][N_REQ-1:0]  data_t;
   logic                         own_valid;
   logic                         own_last;
   logic [ADDR_W-1:0]            own_addr;
   logic [WIDTH-1:0]             own_data;

   for (genvar g = 0; g < N_REQ; g++) begin : g_sel
      assign own_sel[g] = (owner == ID_W'(g));
   end

   for (genvar b = 0; b < ADDR_W; b++) begin : g_addr
      for (genvar g = 0; g < N_REQ; g++) begin : g_addr_bit
         assign addr_t[b][g] = req_addr[g*ADDR_W + b];
      end
      assign own_addr[b] = |(addr_t[b] & own_sel);
   end

   for (genvar b = 0; b < WIDTH; b++) begin : g_data
      for (genvar g = 0; g < N_REQ; g++) begin : g_data_bit
         assign data_t[b][g] = req_data[g*WIDTH + b];
      end
      assign own_data[b] = |(data_t[b] & own_sel);
   end

   assign own_valid = |(req_valid & own_sel);
   assign own_last  = |(req_last & own_sel);

   // ------------------------------------------------------------------
   // Transfer, release and address decode
   // ------------------------------------------------------------------
   logic             xfer;
   logic             burst_end;
   logic             release_now;
   logic [ID_W-1:0]  next_rr;
   logic [N_REG-1:0] addr_dec;
   logic             addr_bad;

   for (genvar r = 0; r < N_REG; r++) begin : g_dec
      assign addr_dec[r] = (own_addr == ADDR_W'(r));
   end

   assign xfer        = (state == OWNED) && own_valid;
   assign burst_end   = (32'(burst_cnt) == MAX_BURST - 1);
   assign release_now = !own_valid || own_last || burst_end;
   assign next_rr     = (owner == ID_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
   assign addr_bad    = (32'(own_addr) >= N_REG);

   // Ownership FSM: grant from IDLE, release on last/burst limit/valid drop
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         owner     <= '0;
         rr_ptr    <= '0;
         burst_cnt <= '0;
         req_ready <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  state     <= OWNED;
                  owner     <= pick;
                  burst_cnt <= '0;
                  req_ready <= first;
               end
            end
            OWNED: begin
               if (own_valid) begin
                  burst_cnt <= burst_cnt + 1'b1;
               end
               if (release_now) begin
                  state     <= IDLE;
                  owner     <= '0;
                  rr_ptr    <= next_rr;
                  req_ready <= '0;
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= '0;
            end
         endcase
      end
   end

   // Registered write path: strobe one cycle after the accepted write
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reg_load <= '0;
         reg_in   <= '0;
         err_addr <= 1'b0;
      end else begin
         reg_load <= '0;
         err_addr <= 1'b0;
         if (xfer) begin
            reg_load <= addr_dec;
            reg_in   <= own_data;
            err_addr <= addr_bad;
         end
      end
   end

   assign busy     = (state == OWNED);
   assign grant_id = owner;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: vector table of single writes,
// hand-written multi-cycle sequences, and a strobe scoreboard.
module tb_reg_write_arbiter;

   localparam int N_REQ     = 4;
   localparam int WIDTH     = 16;
   localparam int N_REG     = 6;
   localparam int ADDR_W    = 3;
   localparam int MAX_BURST = 4;
   localparam int AB        = N_REQ * ADDR_W;
   localparam int DB        = N_REQ * WIDTH;
   localparam int NV        = 6;

   logic             clk = 1'b0;
   logic             reset;
   logic [N_REQ-1:0] req_valid;
   logic [N_REQ-1:0] req_last;
   logic [AB-1:0]    req_addr;
   logic [DB-1:0]    req_data;
   logic [N_REQ-1:0] req_ready;
   logic [N_REG-1:0] reg_load;
   logic [WIDTH-1:0] reg_in;
   logic [2:0]       grant_id;
   logic             busy;
   logic             err_addr;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic [N_REG-1:0] load;
      logic [WIDTH-1:0] data;
      logic             err;
   } strobe_t;

   typedef struct {
      int               r;
      logic [ADDR_W-1:0] addr;
      logic [WIDTH-1:0] data;
      logic [N_REG-1:0] load;
      logic             err;
   } vec_t;

   strobe_t          sb[$];
   strobe_t          mon_e;
   vec_t             vt[NV];
   logic [WIDTH-1:0] bank[N_REG] = '{default: '0};

   reg_write_arbiter #(
      .N_REQ     (N_REQ),
      .WIDTH     (WIDTH),
      .N_REG     (N_REG),
      .ADDR_W    (ADDR_W),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_last  (req_last),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_ready (req_ready),
      .reg_load  (reg_load),
      .reg_in    (reg_in),
      .grant_id  (grant_id),
      .busy      (busy),
      .err_addr  (err_addr)
   );

   always #5 clk = ~clk;

   // Register bank fed by the arbiter
   always @(posedge clk) begin
      for (int r = 0; r < N_REG; r++) begin
         if (reg_load[r]) bank[r] <= reg_in;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every strobe the DUT emits must match the oldest expected one
   always @(negedge clk) begin
      if (!reset && (reg_load !== '0 || err_addr !== 1'b0)) begin
         if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL sb_spurious: got load=%b err=%b expected no strobe (t=%0t)",
                     reg_load, err_addr, $time);
         end else begin
            mon_e = sb.pop_front();
            chk("sb_load", 32'(reg_load), 32'(mon_e.load));
            chk("sb_err", 32'(err_addr), 32'(mon_e.err));
            if (!mon_e.err) chk("sb_data", 32'(reg_in), 32'(mon_e.data));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [N_REG-1:0] l, input logic [WIDTH-1:0] d, input logic e);
      sb.push_back('{l, d, e});
   endtask

   task automatic set_req(input int r, input logic v, input logic l,
                          input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
      logic [N_REQ-1:0] m;
      m         = N_REQ'(1) << r;
      req_valid = v ? (req_valid | m) : (req_valid & ~m);
      req_last  = l ? (req_last | m) : (req_last & ~m);
      req_addr  = (req_addr & ~(AB'({ADDR_W{1'b1}}) << (r * ADDR_W))) | (AB'(a) << (r * ADDR_W));
      req_data  = (req_data & ~(DB'({WIDTH{1'b1}}) << (r * WIDTH))) | (DB'(d) << (r * WIDTH));
   endtask

   task automatic drop(input int r);
      logic [N_REQ-1:0] m;
      m         = N_REQ'(1) << r;
      req_valid = req_valid & ~m;
      req_last  = req_last & ~m;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      sb.delete();
      req_valid = '0;
      req_last  = '0;
      req_addr  = '0;
      req_data  = '0;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      vt[0] = '{1, 3'd3, 16'hBEEF, 6'b001000, 1'b0};
      vt[1] = '{3, 3'd7, 16'h00FF, 6'b000000, 1'b1};
      vt[2] = '{0, 3'd5, 16'h5A5A, 6'b100000, 1'b0};
      vt[3] = '{2, 3'd0, 16'h0001, 6'b000001, 1'b0};
      vt[4] = '{3, 3'd6, 16'hFFFF, 6'b000000, 1'b1};
      vt[5] = '{1, 3'd1, 16'h8001, 6'b000010, 1'b0};

      reset     = 1'b1;
      req_valid = '0;
      req_last  = '0;
      req_addr  = '0;
      req_data  = '0;
      tick();
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_grant", 32'(grant_id), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_load", 32'(reg_load), 32'd0);
      chk("rst_regin", 32'(reg_in), 32'd0);
      chk("rst_err", 32'(err_addr), 32'd0);
      reset = 1'b0;
      tick();

      // Reset hitting the strobe cycle discards the write
      set_req(0, 1'b1, 1'b1, 3'd2, 16'h1234);
      push_exp(6'b000100, 16'h1234, 1'b0);
      tick();
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_grant", 32'(grant_id), 32'd0);
      chk("t1_ready", 32'(req_ready), 32'b0001);
      tick();
      chk("t1_strobe", 32'(reg_load), 32'b000100);
      drop(0);
      reset = 1'b1;
      sb.delete();
      #1;
      chk("t1_rst_load", 32'(reg_load), 32'd0);
      chk("t1_rst_busy", 32'(busy), 32'd0);
      tick();
      tick();
      reset = 1'b0;
      chk("t1_bank2", 32'(bank[2]), 32'd0);
      // rr_ptr back at 0: req0 wins over req1
      set_req(0, 1'b1, 1'b1, 3'd2, 16'h5678);
      set_req(1, 1'b1, 1'b1, 3'd4, 16'h9ABC);
      push_exp(6'b000100, 16'h5678, 1'b0);
      push_exp(6'b010000, 16'h9ABC, 1'b0);
      tick();
      chk("t1_regrant", 32'(grant_id), 32'd0);
      chk("t1_regrant_busy", 32'(busy), 32'd1);
      tick();
      drop(0);
      chk("t1_gap", 32'(busy), 32'd0);
      tick();
      chk("t1_next", 32'(grant_id), 32'd1);
      tick();
      drop(1);
      chk("t1_done", 32'(busy), 32'd0);
      tick();
      chk("t1_bank2_new", 32'(bank[2]), 32'h5678);
      chk("t1_bank4_new", 32'(bank[4]), 32'h9ABC);

      // Table of single writes, including out-of-range addresses
      for (int i = 0; i < NV; i++) begin
         set_req(vt[i].r, 1'b1, 1'b1, vt[i].addr, vt[i].data);
         push_exp(vt[i].load, vt[i].data, vt[i].err);
         tick();
         chk("tv_busy", 32'(busy), 32'd1);
         chk("tv_grant", 32'(grant_id), 32'(vt[i].r));
         chk("tv_ready", 32'(req_ready), 32'(N_REQ'(1) << vt[i].r));
         chk("tv_noload", 32'(reg_load), 32'd0);
         tick();
         drop(vt[i].r);
         chk("tv_idle", 32'(busy), 32'd0);
         chk("tv_grant0", 32'(grant_id), 32'd0);
         chk("tv_ready0", 32'(req_ready), 32'd0);
         chk("tv_load", 32'(reg_load), 32'(vt[i].load));
         chk("tv_err", 32'(err_addr), 32'(vt[i].err));
         if (!vt[i].err) chk("tv_regin", 32'(reg_in), 32'(vt[i].data));
         tick();
         chk("tv_load_off", 32'(reg_load), 32'd0);
         chk("tv_err_off", 32'(err_addr), 32'd0);
         if (!vt[i].err) chk("tv_regin_hold", 32'(reg_in), 32'(vt[i].data));
      end

      // All four continuously valid: grants 0,1,2,3,0 with an idle gap
      do_reset();
      for (int r = 0; r < N_REQ; r++) begin
         set_req(r, 1'b1, 1'b1, ADDR_W'(r), 16'hA000 + 16'(r));
      end
      for (int g = 0; g < 5; g++) begin
         push_exp(N_REG'(1) << (g % N_REQ), 16'hA000 + 16'(g % N_REQ), 1'b0);
         tick();
         chk("t3_busy", 32'(busy), 32'd1);
         chk("t3_grant", 32'(grant_id), 32'(g % N_REQ));
         chk("t3_ready", 32'(req_ready), 32'(N_REQ'(1) << (g % N_REQ)));
         tick();
         chk("t3_gap", 32'(busy), 32'd0);
      end
      req_valid = '0;
      req_last  = '0;
      tick();
      tick();
      chk("t3_end", 32'(busy), 32'd0);

      // Burst limit: six writes from req2, forced release after four
      set_req(2, 1'b1, 1'b0, 3'd0, 16'hC000);
      push_exp(6'b000001, 16'hC000, 1'b0);
      tick();
      chk("t4_grant", 32'(grant_id), 32'd2);
      for (int k = 0; k < 4; k++) begin
         tick();
         set_req(2, 1'b1, 1'b0, ADDR_W'(k + 1), 16'hC000 + 16'(k + 1));
         push_exp(N_REG'(1) << (k + 1), 16'hC000 + 16'(k + 1), 1'b0);
         chk("t4_busy", 32'(busy), (k < 3) ? 32'd1 : 32'd0);
      end
      tick();
      chk("t4_regrant", 32'(busy), 32'd1);
      chk("t4_regrant_id", 32'(grant_id), 32'd2);
      tick();
      set_req(2, 1'b1, 1'b0, 3'd5, 16'hC005);
      push_exp(6'b100000, 16'hC005, 1'b0);
      chk("t4_busy5", 32'(busy), 32'd1);
      tick();
      drop(2);
      chk("t4_busy6", 32'(busy), 32'd1);
      tick();
      chk("t4_release", 32'(busy), 32'd0);
      chk("t4_noload", 32'(reg_load), 32'd0);

      // Owner drops valid mid-burst: release, then req1 granted
      do_reset();
      set_req(0, 1'b1, 1'b0, 3'd1, 16'hD001);
      set_req(1, 1'b1, 1'b1, 3'd2, 16'hD102);
      push_exp(6'b000010, 16'hD001, 1'b0);
      tick();
      chk("t6_grant", 32'(grant_id), 32'd0);
      tick();
      set_req(0, 1'b1, 1'b0, 3'd4, 16'hD004);
      push_exp(6'b010000, 16'hD004, 1'b0);
      push_exp(6'b000100, 16'hD102, 1'b0);
      chk("t6_busy1", 32'(busy), 32'd1);
      tick();
      drop(0);
      chk("t6_busy2", 32'(busy), 32'd1);
      chk("t6_owner2", 32'(grant_id), 32'd0);
      tick();
      chk("t6_release", 32'(busy), 32'd0);
      chk("t6_nostrobe", 32'(reg_load), 32'd0);
      tick();
      chk("t6_next", 32'(grant_id), 32'd1);
      chk("t6_next_busy", 32'(busy), 32'd1);
      tick();
      drop(1);
      chk("t6_done", 32'(busy), 32'd0);
      chk("t6_load", 32'(reg_load), 32'b000100);
      chk("t6_regin", 32'(reg_in), 32'hD102);
      tick();
      tick();
      chk("sb_drain", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
